// File: rtl/iob_system_sim_uart_if.sv
// IOb-native request/response bundle between the simulation host and the console UART.
interface iob_system_sim_uart_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic                iob_valid_i;
  logic [ADDR_W-1:0]   iob_addr_i;
  logic [DATA_W-1:0]   iob_wdata_i;
  logic [DATA_W/8-1:0] iob_wstrb_i;
  logic [DATA_W-1:0]   iob_rdata_o;
  logic                iob_ready_o;
  logic                iob_rvalid_o;

  modport slave (
    input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    output iob_rdata_o, iob_ready_o, iob_rvalid_o
  );
  modport master (
    output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    input  iob_rdata_o, iob_ready_o, iob_rvalid_o
  );
endinterface

// File: rtl/iob_system_sim_uart.sv
// Console-side 8N1 UART with an IOb CSR view: TX/RX ready flags, TX push, RX pop.
module iob_system_sim_uart #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cke_i,
  iob_system_sim_uart_if.slave  iob,
  output logic                  txd_o,
  input  logic                  rxd_i
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

  localparam logic [ADDR_W-1:0] A_SOFT = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_RXRD = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_DIV  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_TXEN = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_RXEN = ADDR_W'(6);

  logic [15:0] div_r, div_eff, half;
  logic        txen, rxen, softreset, rxready, txready;
  logic [7:0]  rxdata;
  logic        wr, rd;
  logic [DATA_W-1:0] rd_val;

  assign wr = iob.iob_valid_i &&  (|iob.iob_wstrb_i);
  assign rd = iob.iob_valid_i && !(|iob.iob_wstrb_i);
  assign iob.iob_ready_o = 1'b1;

  // Divisors below 2 would leave no room for a mid-bit sample
  assign div_eff = (div_r < 16'd2) ? 16'd2 : div_r;
  assign half    = div_eff >> 1;

  // ---------------- TX ----------------
  st_t        tx_st, tx_nxt;
  logic [15:0] tx_cnt, tx_cnt_nxt;
  logic [7:0]  tx_sh, tx_sh_nxt;
  logic [2:0]  tx_bit, tx_bit_nxt;
  logic        tx_last, tx_load;

  assign txready = txen && (tx_st == S_IDLE) && !softreset;
  assign tx_load = wr && (iob.iob_addr_i == A_DATA) && txready;
  assign tx_last = (tx_cnt == div_eff - 16'd1);

  always_comb begin
    tx_nxt     = tx_st;
    tx_cnt_nxt = tx_cnt;
    tx_sh_nxt  = tx_sh;
    tx_bit_nxt = tx_bit;
    case (tx_st)
      S_IDLE: if (tx_load) begin
        tx_nxt     = S_START;
        tx_cnt_nxt = '0;
        tx_sh_nxt  = iob.iob_wdata_i[7:0];
      end
      S_START: if (tx_last) begin
        tx_nxt     = S_DATA;
        tx_cnt_nxt = '0;
        tx_bit_nxt = '0;
      end else tx_cnt_nxt = tx_cnt + 16'd1;
      S_DATA: if (tx_last) begin
        tx_cnt_nxt = '0;
        tx_sh_nxt  = tx_sh >> 1;
        if (tx_bit == 3'd7) tx_nxt = S_STOP;
        else tx_bit_nxt = tx_bit + 3'd1;
      end else tx_cnt_nxt = tx_cnt + 16'd1;
      S_STOP: if (tx_last) tx_nxt = S_IDLE;
              else tx_cnt_nxt = tx_cnt + 16'd1;
      default: tx_nxt = S_IDLE;
    endcase
    if (softreset) begin
      tx_nxt     = S_IDLE;
      tx_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i)
    if (!arst_i) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_sh  <= '0;
      tx_bit <= '0;
    end else if (cke_i) begin
      tx_st  <= tx_nxt;
      tx_cnt <= tx_cnt_nxt;
      tx_sh  <= tx_sh_nxt;
      tx_bit <= tx_bit_nxt;
    end

  // Softreset drives the line idle in the same cycle it is seen
  assign txd_o = softreset          ? 1'b1 :
                 (tx_st == S_START) ? 1'b0 :
                 (tx_st == S_DATA)  ? tx_sh[0] : 1'b1;

  // ---------------- RX ----------------
  st_t         rx_st, rx_nxt;
  logic [15:0] rx_cnt, rx_cnt_nxt;
  logic [7:0]  rx_sh, rx_sh_nxt;
  logic [2:0]  rx_bit, rx_bit_nxt;
  logic        rx_s1, rx_s2, rx_s3, rx_ok;

  always_comb begin
    rx_nxt     = rx_st;
    rx_cnt_nxt = rx_cnt;
    rx_sh_nxt  = rx_sh;
    rx_bit_nxt = rx_bit;
    rx_ok      = 1'b0;
    case (rx_st)
      S_IDLE: if (rx_s3 && !rx_s2) begin
        rx_nxt     = S_START;
        rx_cnt_nxt = '0;
      end
      S_START: if (rx_cnt == half - 16'd1) begin
        rx_cnt_nxt = '0;
        rx_bit_nxt = '0;
        rx_nxt     = rx_s2 ? S_IDLE : S_DATA;
      end else rx_cnt_nxt = rx_cnt + 16'd1;
      S_DATA: if (rx_cnt == div_eff - 16'd1) begin
        rx_cnt_nxt = '0;
        rx_sh_nxt  = {rx_s2, rx_sh[7:1]};
        if (rx_bit == 3'd7) rx_nxt = S_STOP;
        else rx_bit_nxt = rx_bit + 3'd1;
      end else rx_cnt_nxt = rx_cnt + 16'd1;
      S_STOP: if (rx_cnt == div_eff - 16'd1) begin
        rx_nxt = S_IDLE;
        rx_ok  = rx_s2;
      end else rx_cnt_nxt = rx_cnt + 16'd1;
      default: rx_nxt = S_IDLE;
    endcase
    if (!rxen || softreset) begin
      rx_nxt     = S_IDLE;
      rx_cnt_nxt = '0;
      rx_ok      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i)
    if (!arst_i) begin
      rx_st  <= S_IDLE;
      rx_cnt <= '0;
      rx_sh  <= '0;
      rx_bit <= '0;
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_s3  <= 1'b1;
    end else if (cke_i) begin
      rx_st  <= rx_nxt;
      rx_cnt <= rx_cnt_nxt;
      rx_sh  <= rx_sh_nxt;
      rx_bit <= rx_bit_nxt;
      rx_s1  <= rxd_i;
      rx_s2  <= rx_s1;
      rx_s3  <= rx_s2;
    end

  // ---------------- CSRs ----------------
  always_comb begin
    rd_val = '0;
    case (iob.iob_addr_i)
      A_SOFT:  rd_val[0]   = txready;
      A_RXRD:  rd_val[8]   = rxready;
      A_DATA:  rd_val[7:0] = rxdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i)
    if (!arst_i) begin
      div_r            <= '0;
      txen             <= 1'b0;
      rxen             <= 1'b0;
      softreset        <= 1'b0;
      rxready          <= 1'b0;
      rxdata           <= '0;
      iob.iob_rdata_o  <= '0;
      iob.iob_rvalid_o <= 1'b0;
    end else if (cke_i) begin
      if (wr)
        case (iob.iob_addr_i)
          A_SOFT:  softreset <= iob.iob_wdata_i[0];
          A_DIV:   div_r     <= iob.iob_wdata_i[31:16];
          A_TXEN:  txen      <= iob.iob_wdata_i[8];
          A_RXEN:  rxen      <= iob.iob_wdata_i[16];
          default: ;
        endcase
      iob.iob_rvalid_o <= rd;
      if (rd) iob.iob_rdata_o <= rd_val;
      // A byte landing in the same cycle as a pop takes priority over the clear
      if (softreset) rxready <= 1'b0;
      else if (rx_ok) begin
        rxready <= 1'b1;
        rxdata  <= rx_sh;
      end else if (rd && iob.iob_addr_i == A_DATA) rxready <= 1'b0;
    end
endmodule

// File: tb/tb_iob_system_sim_uart.sv
// Directed bench for iob_system_sim_uart: CSR reads, TX framing, loopback RX, frame error, softreset.
module tb_iob_system_sim_uart;
  logic clk = 1'b0, arst_n = 1'b0, cke = 1'b1;
  logic txd, rxd, tb_rxd = 1'b1, loop = 1'b0;
  int   n_tests = 0, n_fail = 0;

  iob_system_sim_uart_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  assign rxd = loop ? txd : tb_rxd;

  iob_system_sim_uart #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk_i(clk), .arst_i(arst_n), .cke_i(cke), .iob(bus), .txd_o(txd), .rxd_i(rxd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller sits at a negedge; the request occupies the following cycle.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.iob_valid_i = 1'b1; bus.iob_addr_i = a; bus.iob_wdata_i = d; bus.iob_wstrb_i = 4'hF;
    @(negedge clk);
    bus.iob_valid_i = 1'b0; bus.iob_wstrb_i = 4'h0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic v);
    bus.iob_valid_i = 1'b1; bus.iob_addr_i = a; bus.iob_wstrb_i = 4'h0;
    @(negedge clk);
    bus.iob_valid_i = 1'b0;
    d = bus.iob_rdata_o; v = bus.iob_rvalid_o;
  endtask

  function automatic logic [39:0] frame_pat(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] p;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) p[i] = f[i/4];
    return p;
  endfunction

  task automatic tx_capture(output logic [39:0] cap);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      cap[i] = txd;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    tb_rxd = 1'b0; repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin tb_rxd = b[i]; repeat (4) @(negedge clk); end
    tb_rxd = stop; repeat (4) @(negedge clk);
    tb_rxd = 1'b1; repeat (8) @(negedge clk);
  endtask

  task automatic wait_rxready(output logic ok);
    logic [31:0] d;
    logic        v;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      rd(3'd1, d, v);
      ok = d[8];
    end
  endtask

  logic [31:0] d, d2;
  logic        v, v2, ok, acc;
  logic [39:0] cap;

  initial begin
    bus.iob_valid_i = 1'b0; bus.iob_addr_i = '0; bus.iob_wdata_i = '0; bus.iob_wstrb_i = '0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    chk("rst_txd", 40'(txd), 40'd1);
    chk("rst_rvalid", 40'(bus.iob_rvalid_o), 40'd0);
    chk("rst_rdata", 40'(bus.iob_rdata_o), 40'd0);
    chk("rst_ready", 40'(bus.iob_ready_o), 40'd1);

    rd(3'd0, d, v);  rd(3'd1, d2, v2);
    chk("rd0_txready", 40'(d), 40'd0);
    chk("rd0_rvalid", 40'(v), 40'd1);
    chk("rd1_rxready", 40'(d2), 40'd0);
    chk("rd1_rvalid", 40'(v2), 40'd1);
    @(negedge clk);
    chk("rvalid_pulse", 40'(bus.iob_rvalid_o), 40'd0);

    // TX framing at DIV=4
    wr(3'd2, 32'h0004_0000);
    wr(3'd5, 32'h0000_0100);
    rd(3'd0, d, v);
    chk("txready_en", 40'(d), 40'd1);
    wr(3'd4, 32'h55);
    tx_capture(cap);
    chk("tx_55_frame", cap, frame_pat(8'h55));
    rd(3'd0, d, v);  rd(3'd0, d2, v2);
    chk("txready_last", 40'(d), 40'd0);
    chk("txready_back", 40'(d2), 40'd1);
    chk("b2b_rvalid", 40'(v2), 40'd1);

    rd(3'd3, d, v);  chk("unmapped3", 40'(d), 40'd0);
    rd(3'd7, d, v);  chk("unmapped7", 40'(d), 40'd0);

    // Loopback receive
    loop = 1'b1;
    wr(3'd6, 32'h0001_0000);
    wr(3'd4, 32'hA5);
    wait_rxready(ok);
    chk("rx_wait_a5", 40'(ok), 40'd1);
    rd(3'd4, d, v);
    chk("rxdata_a5", 40'(d), 40'hA5);
    rd(3'd4, d, v);
    rd(3'd1, d, v);
    chk("rxready_clr", 40'(d), 40'd0);
    repeat (20) @(negedge clk);
    loop = 1'b0;

    // Frame error, then a good frame of the same byte
    send_rx(8'h3C, 1'b0);
    rd(3'd1, d, v);
    chk("ferr_rxready", 40'(d), 40'd0);
    send_rx(8'h3C, 1'b1);
    rd(3'd1, d, v);
    chk("good_rxready", 40'(d), 40'h100);
    rd(3'd4, d, v);
    chk("rxdata_3c", 40'(d), 40'h3C);

    // Softreset during the start bit
    wr(3'd4, 32'hFF);
    chk("sr_startbit", 40'(txd), 40'd0);
    wr(3'd0, 32'h1);
    chk("sr_txd_high", 40'(txd), 40'd1);
    rd(3'd0, d, v);
    chk("sr_txready", 40'(d), 40'd0);
    wr(3'd0, 32'h0);
    rd(3'd0, d, v);
    chk("sr_release", 40'(d), 40'd1);

    // DIV kept across softreset; busy write discarded
    wr(3'd4, 32'h0F);
    fork
      tx_capture(cap);
      begin repeat (3) @(negedge clk); wr(3'd4, 32'hF0); end
    join
    chk("tx_0f_frame", cap, frame_pat(8'h0F));
    acc = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); acc = acc & txd; end
    chk("busy_discard", 40'(acc), 40'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/iob_system_sim_uart.md
# iob_system_sim_uart

Console-side UART peripheral used by the system simulation wrapper. It gives the simulation host a memory-mapped view of a serial link to the SoC UART. The host polls TX/RX ready flags, pushes bytes to transmit and pops received bytes over an IOb-native slave bus. The serial pins connect to the SoC UART rxd/txd inside the wrapper.

## Interface
- DATA_W, 32: IOb data width.
- ADDR_W, 3: IOb byte-address width (CSR space 0..7).
- clk_i  in  1  system clock; single clock domain.
- arst_i  in  1  asynchronous reset, active-low.
- cke_i  in  1  clock enable; when 0 all state holds.
- iob_valid_i  in  1  request strobe.
- iob_addr_i  in  ADDR_W  byte address.
- iob_wdata_i  in  DATA_W  write data.
- iob_wstrb_i  in  DATA_W/8  byte write strobes; all-zero means read.
- iob_rdata_o  out  DATA_W  read data.
- iob_ready_o  out  1  request accepted.
- iob_rvalid_o  out  1  read data valid.
- txd_o  out  1  serial out, idle high.
- rxd_i  in  1  serial in, idle high.

## Operation
- CSR map, write side:
  - SOFTRESET at 0, 1 bit.
  - DIV at 2, 16 bits, clock cycles per bit.
  - TXDATA at 4, 8 bits.
  - TXEN at 5, 1 bit.
  - RXEN at 6, 1 bit.
- CSR map, read side:
  - TXREADY at 0, 1 bit.
  - RXREADY at 1, 1 bit.
  - RXDATA at 4, 8 bits.
- Field write data is taken from byte lane addr[1:0] of iob_wdata_i; DIV uses lanes 2..3.
- Read data is placed in the same lane; all other rdata bits are 0.
- Unmapped addresses: writes are ignored, reads return 0.
- Frame format: 8N1, LSB first; each bit lasts DIV cycles. DIV values 0 or 1 are treated as 2.
- SOFTRESET=1 while held:
  - TX and RX state machines return to IDLE; txd_o=1; RXREADY=0.
  - DIV, TXEN and RXEN keep their values.
- TX state machine, IDLE -> START -> DATA(8) -> STOP -> IDLE:
  - TXREADY = TXEN and state==IDLE and not SOFTRESET.
  - A TXDATA write while TXREADY=0 is discarded.
  - TXEN=0 holds txd_o high; a frame already in progress completes.
- RX state machine, IDLE -> START -> DATA(8) -> STOP -> IDLE; active only when RXEN=1:
  - Input is synchronized through 2 flops.
  - IDLE detects a falling edge, waits DIV/2 cycles and re-checks low; if high, returns to IDLE.
  - Each data bit and the stop bit are sampled every DIV cycles after that.
  - Stop bit low means frame error: the byte is discarded and RXREADY is unchanged.
  - Good frame: RXDATA is loaded and RXREADY is set. If RXREADY is already 1, the old byte is overwritten and RXREADY stays 1.
- Reading RXDATA clears RXREADY.
- A byte completing in the same cycle as an RXDATA read wins: RXREADY=1, new data loaded.

## Timing
- Reset values:
  - iob_rdata_o=0, iob_rvalid_o=0, txd_o=1.
  - DIV=0, TXEN=0, RXEN=0, SOFTRESET=0, RXREADY=0, RXDATA=0.
- iob_ready_o=1 constantly; every request is accepted in the cycle valid is high.
- Writes take effect at the next clock edge.
- Reads: iob_rvalid_o pulses high for exactly 1 cycle, the cycle after acceptance, with iob_rdata_o valid in that same cycle. Back-to-back reads are supported, one per cycle.
- TXDATA write in cycle t:
  - TXREADY reads 0 from t+1.
  - txd_o start bit begins at t+1.
  - Frame lasts 10*DIV cycles; TXREADY returns to 1 at t+1+10*DIV.
- RXREADY rises 1 cycle after the mid-stop-bit sample.
- RX latency from the start-bit edge to RXREADY: 2 sync cycles + DIV/2 + 9*DIV + 1 cycle.
- cke_i=0 freezes all counters and registers; outputs hold.

## Test plan
- Reset, then read address 0 and address 1 -> TXREADY=0, RXREADY=0; rvalid one cycle after each read.
- Configure DIV=4, TXEN=1, write TXDATA 0x55 -> txd_o shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; TXREADY=0 for 40 cycles, then 1.
- Loop txd_o to rxd_i, RXEN=1, send 0xA5 -> RXREADY=1 and RXDATA=0xA5; a second RXDATA read gives RXREADY=0.
- Drive rxd_i with a frame of 0x3C whose stop bit is 0 -> RXREADY stays 0.
- Start TX of 0xFF, then set SOFTRESET=1 mid-frame -> txd_o=1 next cycle. Release -> TXREADY=1 and DIV still 4.
- Write TXDATA while busy -> discarded; only the first byte appears on txd_o.
